// File: rtl/vga_fb_fill.sv
// Framebuffer write engine: turns pixel / rectangle-fill commands into row-major
// 24-bit writes at y*H_RES+x. Optional clipping of x1/y1 under VGA_FB_FILL_CLIP_EN.
module vga_fb_fill #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [9:0]        cmd_x0,
    input  logic [9:0]        cmd_x1,
    input  logic [9:0]        cmd_y0,
    input  logic [9:0]        cmd_y1,
    input  logic [DATA_W-1:0] cmd_color,
    input  logic              fb_stall,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FILL = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [9:0]        X_MAX    = 10'(H_RES - 1);
    localparam logic [9:0]        Y_MAX    = 10'(V_RES - 1);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t              state_r, state_s;
    logic [9:0]          x0_r, x1_r, y0_r, y1_r, x_r, y_r;
    logic [9:0]          x1_clip_s, y1_clip_s;
    logic [DATA_W-1:0]   color_r;
    logic [ADDR_W-1:0]   row_base_r, addr_r, row_base_s;
    logic                bad_s, last_s;

    // Bounds handling for the captured command, evaluated while in LOAD
    always_comb begin
        x1_clip_s = x1_r;
        y1_clip_s = y1_r;
`ifdef VGA_FB_FILL_CLIP_EN
        if (x1_r > X_MAX) x1_clip_s = X_MAX;
        else              x1_clip_s = x1_r;
        if (y1_r > Y_MAX) y1_clip_s = Y_MAX;
        else              y1_clip_s = y1_r;
`endif
        bad_s = (x0_r > x1_clip_s) || (y0_r > y1_clip_s) ||
                (x1_clip_s > X_MAX) || (y1_clip_s > Y_MAX) ||
                (x0_r > X_MAX) || (y0_r > Y_MAX);
        row_base_s = ADDR_W'(y0_r) * STRIDE;
        last_s     = (x_r == x1_r) && (y_r == y1_r);
    end

    // FSM state register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_r <= S_IDLE;
        else       state_r <= state_s;
    end

    // Next-state and status decode; fb_we reacts to stall within the same cycle
    always_comb begin
        state_s   = state_r;
        cmd_ready = 1'b0;
        fb_we     = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_r)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_s = S_LOAD;
                else           state_s = S_IDLE;
            end
            S_LOAD: begin
                if (bad_s) state_s = S_ERR;
                else       state_s = S_FILL;
            end
            S_FILL: begin
                fb_we = !fb_stall;
                if (!fb_stall && last_s) state_s = S_DONE;
                else                     state_s = S_FILL;
            end
            S_DONE: begin
                done    = 1'b1;
                state_s = S_IDLE;
            end
            S_ERR: begin
                err     = 1'b1;
                state_s = S_IDLE;
            end
            default: state_s = S_IDLE;
        endcase
        busy = !cmd_ready;
    end

    // Command capture and address/coordinate walk
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            x0_r       <= 10'd0;
            x1_r       <= 10'd0;
            y0_r       <= 10'd0;
            y1_r       <= 10'd0;
            x_r        <= 10'd0;
            y_r        <= 10'd0;
            color_r    <= '0;
            row_base_r <= '0;
            addr_r     <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (cmd_valid) begin
                        x0_r    <= cmd_x0;
                        y0_r    <= cmd_y0;
                        color_r <= cmd_color;
                        if (cmd_op) begin
                            x1_r <= cmd_x1;
                            y1_r <= cmd_y1;
                        end else begin
                            x1_r <= cmd_x0;
                            y1_r <= cmd_y0;
                        end
                    end
                end
                S_LOAD: begin
                    if (!bad_s) begin
                        x1_r       <= x1_clip_s;
                        y1_r       <= y1_clip_s;
                        row_base_r <= row_base_s;
                        addr_r     <= row_base_s + ADDR_W'(x0_r);
                        x_r        <= x0_r;
                        y_r        <= y0_r;
                    end
                end
                S_FILL: begin
                    if (!fb_stall) begin
                        if (x_r != x1_r) begin
                            x_r    <= x_r + 10'd1;
                            addr_r <= addr_r + ADDR_ONE;
                        end else if (y_r != y1_r) begin
                            x_r        <= x0_r;
                            y_r        <= y_r + 10'd1;
                            row_base_r <= row_base_r + STRIDE;
                            addr_r     <= row_base_r + STRIDE + ADDR_W'(x0_r);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign fb_addr  = addr_r;
    assign fb_wdata = color_r;

endmodule

// File: tb/tb_vga_fb_fill.sv
// Directed bench for vga_fb_fill: expected writes queued at command time and
// popped by a write monitor; timing of done/err checked against the handshake edge.
module tb_vga_fb_fill;
    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
    logic [9:0]  cmd_x0 = 10'd0, cmd_x1 = 10'd0, cmd_y0 = 10'd0, cmd_y1 = 10'd0;
    logic [23:0] cmd_color = 24'd0;
    logic        fb_stall = 1'b0, fb_we, busy, done, err;
    logic [18:0] fb_addr;
    logic [23:0] fb_wdata;

    int compared = 0, mismatched = 0;
    int cyc = 0, hs = 0;
    int done_cnt = 0, err_cnt = 0, we_cnt = 0;
    int done_edge = -1, err_edge = -1, first_we_edge = -1;
    logic [18:0] last_addr = 19'd0;
    logic [42:0] exp_q[$];

    vga_fb_fill dut (
        .clk(clk), .clrn(clrn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0),
        .cmd_y1(cmd_y1), .cmd_color(cmd_color), .fb_stall(fb_stall),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write/status monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (fb_we) begin
            logic [42:0] e;
            we_cnt++;
            if (first_we_edge < 0) first_we_edge = cyc + 1;
            last_addr = fb_addr;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : {43{1'b1}};
            check("write", {fb_addr, fb_wdata}, e);
            check("we_excl", {done, err}, 2'b00);
        end
        if (fb_stall && clrn) check("stall_we", fb_we, 1'b0);
        if (done) begin done_cnt++; done_edge = cyc + 1; end
        if (err)  begin err_cnt++;  err_edge  = cyc + 1; end
        if (done || err) check("done_err_excl", done & err, 1'b0);
    end

    task automatic send(input logic op, input logic [9:0] x0, input logic [9:0] y0,
                        input logic [9:0] x1, input logic [9:0] y1, input logic [23:0] col);
        int k = 0;
        while (!cmd_ready && k < 100) begin @(posedge clk); #1; k++; end
        if (k >= 100) check("ready_timeout", 1'b0, 1'b1);
        done_cnt = 0; err_cnt = 0; we_cnt = 0;
        done_edge = -1; err_edge = -1; first_we_edge = -1;
        cmd_valid = 1'b1; cmd_op = op; cmd_color = col;
        cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1;
        @(posedge clk); #1;
        hs = cyc;
        cmd_valid = 1'b0;
        cmd_x0 = 10'h3ff; cmd_y0 = 10'h3ff;
    endtask

    task automatic wait_end(input int budget);
        int k = 0;
        while (done_cnt == 0 && err_cnt == 0 && k < budget) begin @(negedge clk); #1; k++; end
        if (k >= budget) check("end_timeout", 1'b0, 1'b1);
        @(negedge clk); #1;
        check("ready_after", cmd_ready, 1'b1);
        check("q_empty", exp_q.size(), 0);
    endtask

    task automatic push_rect(input int x0, input int y0, input int x1, input int y1,
                             input logic [23:0] col);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                exp_q.push_back({19'(y * 640 + x), col});
    endtask

    initial begin
        #2;
        check("reset_outs", {cmd_ready, fb_we, fb_addr, fb_wdata, busy, done, err},
              {1'b1, 1'b0, 19'd0, 24'd0, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1; clrn = 1'b1;
        @(posedge clk); #1;

        // single pixel at (5,2)
        exp_q.push_back({19'd1285, 24'hFF0000});
        send(1'b0, 10'd5, 10'd2, 10'd900, 10'd900, 24'hFF0000);
        check("px_busy", busy, 1'b1);
        wait_end(50);
        check("px_writes", we_cnt, 1);
        check("px_first_we", first_we_edge - hs, 2);
        check("px_done_edge", done_edge - hs, 3);
        check("px_no_err", err_cnt, 0);

        // rectangle across the row boundary
        push_rect(638, 0, 639, 1, 24'h00FF00);
        send(1'b1, 10'd638, 10'd0, 10'd639, 10'd1, 24'h00FF00);
        wait_end(50);
        check("rb_writes", we_cnt, 4);
        check("rb_done_edge", done_edge - hs, 6);

        // stall on the 2nd write cycle for 2 cycles
        push_rect(0, 0, 3, 0, 24'h123456);
        send(1'b1, 10'd0, 10'd0, 10'd3, 10'd0, 24'h123456);
        @(posedge clk); #1;
        @(posedge clk); #1; fb_stall = 1'b1;
        @(posedge clk);
        @(posedge clk); #1; fb_stall = 1'b0;
        wait_end(50);
        check("st_writes", we_cnt, 4);
        check("st_done_edge", done_edge - hs, 8);

        // inverted x range
        send(1'b1, 10'd10, 10'd10, 10'd5, 10'd20, 24'hABCDEF);
        wait_end(50);
        check("inv_err_edge", err_edge - hs, 2);
        check("inv_writes", we_cnt, 0);
        check("inv_no_done", done_cnt, 0);

        // out-of-range rectangle
`ifdef VGA_FB_FILL_CLIP_EN
        push_rect(600, 470, 639, 479, 24'h0000FF);
`endif
        send(1'b1, 10'd600, 10'd470, 10'd700, 10'd479, 24'h0000FF);
        wait_end(1000);
`ifdef VGA_FB_FILL_CLIP_EN
        check("clip_writes", we_cnt, 400);
        check("clip_last", last_addr, 19'd307199);
        check("clip_done_edge", done_edge - hs, 402);
`else
        check("oor_err", err_cnt, 1);
        check("oor_writes", we_cnt, 0);
`endif

        // reset during the 3rd write of a 4x4 fill
        push_rect(0, 0, 1, 0, 24'h777777);
        send(1'b1, 10'd0, 10'd0, 10'd3, 10'd3, 24'h777777);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        check("pre_rst_we", fb_we, 1'b1);
        clrn = 1'b0;
        #1;
        check("rst_we_drop", fb_we, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk); #1; clrn = 1'b1;
        repeat (3) begin @(negedge clk); #1; end
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_no_done", {done_cnt, err_cnt}, 64'd0);
        check("rst_writes", we_cnt, 2);
        check("rst_q_empty", exp_q.size(), 0);
        check("rst_addr", fb_addr, 19'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/vga_fb_fill.md
# vga_fb_fill

Framebuffer write engine sitting upstream of the VGA framebuffer lookup and `vga_ctrl` display path. It accepts single-pixel and rectangle-fill commands over a valid/ready handshake. It converts (x, y) coordinates into linear framebuffer addresses using the display stride of `H_RES` words per row, and issues one 24-bit RGB write per cycle into the framebuffer's write port. The read side then scans the written pixels out to the display.

## Interface
- `H_RES`, 640, pixels per row; also the row stride in words
- `V_RES`, 480, visible rows
- `ADDR_W`, 19, framebuffer word-address width
- `DATA_W`, 24, pixel width, {R[23:16], G[15:8], B[7:0]}
- `clk`  in  1  single clock; all logic on rising edge
- `clrn`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  engine idle and able to accept a command
- `cmd_op`  in  1  0 = single pixel at (x0, y0); 1 = filled rectangle (x0, y0)..(x1, y1), inclusive
- `cmd_x0`, `cmd_x1`  in  10  column coordinates
- `cmd_y0`, `cmd_y1`  in  10  row coordinates
- `cmd_color`  in  `DATA_W`  fill colour
- `fb_stall`  in  1  framebuffer port cannot take a write this cycle
- `fb_we`  out  1  write strobe
- `fb_addr`  out  `ADDR_W`  word address, y*`H_RES`+x
- `fb_wdata`  out  `DATA_W`  write data
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle pulse after the last write of a command
- `err`  out  1  one-cycle pulse when a command is rejected

## Operation
- The FSM has five states: IDLE, LOAD, FILL, DONE, ERR.
- IDLE:
  - `cmd_ready`=1.
  - When `cmd_valid & cmd_ready` on a clock edge, all `cmd_*` fields are registered and the FSM goes to LOAD.
  - Inputs are ignored while not IDLE.
- Pixel op: `x1`/`y1` are replaced internally by `x0`/`y0` at capture.
- LOAD: validates the registered command and computes the start addresses.
  - Reject if x0>x1, y0>y1, x1≥`H_RES` or y1≥`V_RES`; go to ERR.
  - Otherwise row_base = y0*`H_RES` (constant multiply, `ADDR_W` bits), addr = row_base + x0, x = x0, y = y0; go to FILL.
- FILL:
  - Each cycle with `fb_stall`=0: `fb_we`=1, `fb_addr`=addr, `fb_wdata`=colour.
  - Mid-row (x<x1): x++ and addr++.
  - At row end (x==x1, y<y1): x = x0, y++, row_base += `H_RES`, addr = row_base + `H_RES` + x0.
  - At x==x1 and y==y1 the write is issued and the FSM goes to DONE.
- `fb_stall`=1 in FILL:
  - `fb_we`=0.
  - All counters and addresses hold; `fb_addr`/`fb_wdata` hold their values.
  - The stall adds exactly one cycle per stalled cycle.
- DONE: `done`=1 for one cycle, then IDLE.
- ERR: `err`=1 for one cycle, no write issued, then IDLE.
- Total writes per command = (x1−x0+1)*(y1−y0+1), row-major, ascending addresses within a row.
- Row-boundary arithmetic is exact; addresses never wrap within `ADDR_W` for in-range commands (max 479*640+639 = 307199).

## Timing
- Reset values (asynchronous, on `clrn`=0):
  - State IDLE.
  - `cmd_ready`=1; `fb_we`=0; `fb_addr`=0; `fb_wdata`=0; `busy`=0; `done`=0; `err`=0.
- Handshake accepted at edge T:
  - LOAD during cycle T..T+1.
  - First `fb_we` in the cycle after edge T+1.
- Unstalled N-pixel command:
  - `fb_we` high for exactly N consecutive cycles.
  - `done` in the next cycle.
  - `cmd_ready` high the cycle after `done`.
  - Handshake edge to `done` cycle = N+2 cycles.
- Rejected command: `err` high in the second cycle after the handshake edge; no `fb_we`.
- `cmd_valid` is held by the producer until `cmd_ready` is seen; it may drop without penalty while `cmd_ready`=0.
- Reset mid-FILL:
  - `fb_we` drops immediately (asynchronously).
  - No `done` or `err` is produced.
  - The partial fill is left as written.
- `done` and `err` are mutually exclusive and never assert together with `fb_we`.

## Configuration
- `VGA_FB_FILL_CLIP_EN` defined:
  - In LOAD, x1 is clamped to `H_RES`−1 and y1 to `V_RES`−1 before the checks.
  - Commands with x0≥`H_RES` or y0≥`V_RES` still raise `err`.
  - x0>x1 and y0>y1 checks apply after clamping.
- Not defined: any out-of-range coordinate raises `err` and no writes occur.

## Test plan
- Reset with `clrn`=0, then release:
  - All outputs at reset values.
  - Pixel op at (5,2), colour 24'hFF0000 → exactly one `fb_we` with `fb_addr`=1285, `fb_wdata`=24'hFF0000, then `done` pulse.
- Rectangle (638,0)..(639,1), colour 24'h00FF00 → `fb_addr` sequence 638, 639, 1278, 1279 on 4 consecutive cycles; `done` 6 cycles after the handshake edge.
- Rectangle (0,0)..(3,0) with `fb_stall` high on the 2nd write cycle for 2 cycles → addresses 0,1,2,3, each written once; `fb_we` low on the stalled cycles; `done` 2 cycles later than unstalled.
- Rectangle (10,10)..(5,20) → `err` pulse, zero `fb_we`, `cmd_ready` back high.
- Rectangle (600,470)..(700,479):
  - Without macro: `err`, no writes.
  - With `VGA_FB_FILL_CLIP_EN`: 400 writes, last `fb_addr`=307199.
- Assert `clrn`=0 during the 3rd write of a 4×4 fill → `fb_we` low immediately; after release, `cmd_ready`=1 and no `done` pulse.
